// File: rtl/serial_sub_with_borrow.sv
// +--------------------------------------------------------------------------+
// | Module      : serial_sub_with_borrow                                     |
// | Description : Bit-serial LSB-first unsigned subtractor (a - b) with a     |
// |               single borrow flop and start/busy/done handshake.          |
// | Options     : SERIAL_SUB_ZERO_FLAG_EN adds a registered zero output.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_sub_with_borrow #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;

    logic             w_x, w_y, w_dbit, w_br_next;
    logic [WIDTH-1:0] w_diff_shift;

    assign w_x          = a_q[0];
    assign w_y          = b_q[0];
    assign w_dbit       = w_x ^ w_y ^ br_q;
    assign w_br_next    = (~w_x & w_y) | (~(w_x ^ w_y) & br_q);
    assign w_diff_shift = {w_dbit, diff_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = done_q;
        zero_d   = zero_q;
        case (state_q)
            c_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    state_d  = c_SHIFT;
                    a_d      = a;
                    b_d      = b;
                    br_d     = 1'b0;
                    cnt_d    = '0;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    zero_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            c_SHIFT: begin
                diff_d = w_diff_shift;
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = w_br_next;
                cnt_d  = cnt_q + CW'(1);
                // Final bit: publish result and borrow alongside the done pulse
                if (cnt_q == c_LAST) begin
                    state_d  = c_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    borrow_d = w_br_next;
                    zero_d   = (w_diff_shift == '0);
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = c_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    assign zero = zero_q;
`else
    logic w_unused_zero;
    assign w_unused_zero = zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_with_borrow.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_sub_with_borrow                                  |
// | Description : Directed self-checking bench for serial_sub_with_borrow.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_serial_sub_with_borrow;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub_with_borrow #(.WIDTH(WIDTH)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        .zero   (zero),
`endif
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Start at edge 0; values seen at edge n are sampled on the preceding negedge.
    // glitch_n > 0 pulses start with a=b=FF so that it is sampled at edge glitch_n.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input int glitch_n,
                          input logic [7:0] ed, input logic eb, input logic ez);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(posedge clk);
        for (int n = 1; n <= WIDTH + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a     = ~ta;
                b     = ~tb;
            end
            if (n == glitch_n) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else if (glitch_n > 0 && n == glitch_n + 1) begin
                start = 1'b0;
            end
            check($sformatf("busy@%0d", n), {31'd0, busy}, {31'd0, (n <= WIDTH)});
            check($sformatf("done@%0d", n), {31'd0, done}, {31'd0, (n == WIDTH + 1)});
        end
        check("diff", {24'd0, diff}, {24'd0, ed});
        check("borrow", {31'd0, borrow}, {31'd0, eb});
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        check("zero", {31'd0, zero}, {31'd0, ez});
`else
        if (ez) check("zero_absent", 32'd0, 32'd0 + {31'd0, borrow & 1'b0});
`endif
        @(negedge clk);
        check("done_single", {31'd0, done}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 0, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 0, 8'hFE, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_diff", {24'd0, diff}, 32'h0000_00FE);
            check("hold_borrow", {31'd0, borrow}, 32'd1);
            check("hold_done", {31'd0, done}, 32'd0);
        end
        run_op(8'hA5, 8'hA5, 0, 8'h00, 1'b0, 1'b1);
        run_op(8'h00, 8'h01, 0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h7F, 0, 8'h01, 1'b0, 1'b0);
        run_op(8'h10, 8'h01, 4, 8'h0F, 1'b0, 1'b0);

        // Reset asserted between edges while the operation is in flight
        @(negedge clk);
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_diff", {24'd0, diff}, 32'd0);
        check("arst_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        check("arst_zero", {31'd0, zero}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h09, 8'h04, 0, 8'h05, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/serial_sub_with_borrow.md
# serial_sub_with_borrow

Bit-serial unsigned subtractor that computes `a - b` LSB-first, one bit per clock. It uses a half-subtract-with-borrow datapath and a single borrow flip-flop carried between bit positions. It is the subtraction counterpart to the half adder with carry flag, and is the first sequential arithmetic block in the circuit set. It sits between a simple start/done requester and whatever consumes the difference and borrow flag.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range 2..32.

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `start`  input  1  request; sampled only in IDLE
- `a`  input  WIDTH  minuend; captured on accepted start
- `b`  input  WIDTH  subtrahend; captured on accepted start
- `busy`  output  1  high while in SHIFT
- `done`  output  1  one-cycle pulse when the result becomes valid
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`
- `borrow`  output  1  final borrow; 1 iff `a < b` unsigned

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - With `start`=1, capture `a` and `b` into shift registers, clear the borrow flop, clear the bit counter, and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:** each cycle, take operand bits `x` and `y` at position 0 with borrow-in `br`:
  - `d = x ^ y ^ br`
  - `br_next = (~x & y) | (~(x ^ y) & br)`
  - Shift `d` into `diff` at the MSB, right-shifting `diff`; right-shift both operand registers.
  - Increment the counter. After WIDTH shift cycles, go to DONE.
- **DONE:**
  - `done`=1 for exactly this cycle.
  - `borrow` = final `br_next`.
  - Go to IDLE.
- `diff` and `borrow` hold their values from DONE until the next accepted start.
- **Start handling:**
  - `start` in SHIFT or DONE is ignored; it is not queued.
  - Changes to `a` and `b` after capture have no effect.
- **Arithmetic:** wrap-around modulo 2^WIDTH. Example: 0x00 - 0x01 gives `diff`=0xFF, `borrow`=1.
- **Reset:** `rst_n`=0 at any time, including mid-SHIFT, asynchronously forces:
  - state IDLE;
  - counter 0;
  - operand registers, `diff`, `borrow`, `busy`, `done`, and `zero` (if present) all to 0.
  - The operation in progress is discarded.

## Timing
- Call cycle 0 the clock edge at which `start` is sampled high in IDLE.
- `busy`=1 in cycles 1..WIDTH.
- `done`=1 in cycle WIDTH+1; latency from start to done is WIDTH+1 clocks.
- The earliest next start is accepted at cycle WIDTH+2, giving throughput of one result per WIDTH+2 clocks.
- All outputs are registered. No combinational path from inputs to outputs.
- `busy` and `done` are never high together.

## Configuration
- **`SERIAL_SUB_ZERO_FLAG_EN` defined:**
  - Adds output port `zero` (output, 1 bit), registered.
  - `zero` is set in DONE iff the final `diff` == 0, and holds with `diff`.
  - `zero` resets to 0 and clears on accepted start.
- **Macro undefined:** the `zero` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Basic subtract:** WIDTH=8, start with `a`=0x05, `b`=0x03 at cycle 0.
  - `busy` high cycles 1-8.
  - `done` pulse at cycle 9 with `diff`=0x02, `borrow`=0.
- **Negative result:** `a`=0x03, `b`=0x05.
  - `diff`=0xFE, `borrow`=1 at done.
  - Values held for 5 idle cycles afterwards.
- **Equal operands:** `a`=0xA5, `b`=0xA5.
  - `diff`=0x00, `borrow`=0.
  - `zero`=1 with the macro defined; no `zero` port without it.
- **Borrow chain:** `a`=0x00, `b`=0x01 → `diff`=0xFF, `borrow`=1. `a`=0x80, `b`=0x7F → `diff`=0x01, `borrow`=0.
- **Start while busy:** start `a`=0x10, `b`=0x01. Pulse `start` again at cycle 4 with `a`=0xFF, `b`=0xFF.
  - Result is `diff`=0x0F, `borrow`=0 at cycle 9.
  - Exactly one `done` pulse.
- **Reset mid-operation:** deassert `rst_n` between edges during cycle 4.
  - All outputs go 0 immediately, without waiting for a clock edge.
  - After release, a new start with `a`=0x09, `b`=0x04 produces `diff`=0x05, `borrow`=0 at WIDTH+1.
